// File: rtl/fdiv_seq.sv
// fdiv_seq: iterative IEEE-754 single/half divider, one restoring quotient bit per clock
module fdiv_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        mode_fp,
  input  logic        round_mode,
  output logic        busy,
  output logic        done,
  output logic [31:0] re,
  output logic        flag_dz,
  output logic        flag_nv
);
  typedef enum logic [1:0] {IDLE, UNPACK, DIVIDE, ROUND} state_t;
  localparam logic [1:0] K_NORM = 2'd0, K_NAN = 2'd1, K_INF = 2'd2, K_ZERO = 2'd3;
  state_t state_q, state_d;
  logic [31:0] a_q, a_d, b_q, b_d, re_q, re_d;
  logic sp_q, sp_d, rm_q, rm_d, s_q, s_d, pdz_q, pdz_d;
  logic dz_q, dz_d, nv_q, nv_d, done_q, done_d;
  logic [1:0] kind_q, kind_d, kind_u;
  logic [25:0] r_q, r_d, diff;
  logic [24:0] q_q, q_d;
  logic [23:0] mb_q, mb_d, ma, mb;
  logic [9:0] e_q, e_d, e2;
  logic [4:0] cnt_q, cnt_d;
  logic [7:0] ea, eb, emax, eo;
  logic [22:0] fa, fb, fq, fr, fo;
  logic sa, sb, na, nb, ia, ib, za, zb, lt, qbit, inc, cy, ovf, unf, so;
  logic [31:0] res;
  assign emax = sp_q ? 8'hFF : 8'h1F;
  assign ea = sp_q ? a_q[30:23] : {3'b0, a_q[14:10]};
  assign eb = sp_q ? b_q[30:23] : {3'b0, b_q[14:10]};
  assign fa = sp_q ? a_q[22:0] : {13'b0, a_q[9:0]};
  assign fb = sp_q ? b_q[22:0] : {13'b0, b_q[9:0]};
  assign sa = sp_q ? a_q[31] : a_q[15];
  assign sb = sp_q ? b_q[31] : b_q[15];
  assign ma = sp_q ? {1'b1, fa} : {13'b0, 1'b1, fa[9:0]};
  assign mb = sp_q ? {1'b1, fb} : {13'b0, 1'b1, fb[9:0]};
  assign na = (ea == emax) && (fa != '0);
  assign nb = (eb == emax) && (fb != '0);
  assign ia = (ea == emax) && (fa == '0);
  assign ib = (eb == emax) && (fb == '0);
  assign za = ea == '0;
  assign zb = eb == '0;
  assign lt = ma < mb;
  assign kind_u = (na | nb | (za & zb) | (ia & ib)) ? K_NAN : (ia | zb) ? K_INF :
                  (za | ib) ? K_ZERO : K_NORM;
  assign qbit = r_q >= {2'b0, mb_q};
  assign diff = r_q - {2'b0, mb_q};
  // q keeps frac/G/R only; the hidden 1 of a single quotient shifts out the top
  assign fq = sp_q ? q_q[24:2] : {13'b0, q_q[11:2]};
  assign inc = ~rm_q & q_q[1] & (q_q[0] | (r_q != '0) | q_q[2]);
  assign cy = inc & (sp_q ? &q_q[24:2] : &q_q[11:2]);
  assign fr = fq + {22'b0, inc};
  assign e2 = e_q + {9'b0, cy};
  assign ovf = $signed(e2) >= $signed({2'b0, emax});
  assign unf = $signed(e2) <= 10'sd0;
  assign eo = (kind_q == K_NAN || kind_q == K_INF) ? emax : kind_q == K_ZERO ? 8'd0 :
              ovf ? emax - {7'b0, rm_q} : unf ? 8'd0 : e2[7:0];
  assign fo = kind_q == K_NAN ? (sp_q ? 23'h400000 : 23'h000200) : kind_q != K_NORM ? 23'd0 :
              ovf ? {23{rm_q}} : unf ? 23'd0 : fr;
  assign so = (kind_q != K_NAN) & s_q;
  assign res = sp_q ? {so, eo, fo} : {16'b0, so, eo[4:0], fo[9:0]};
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    sp_d = sp_q;
    rm_d = rm_q;
    s_d = s_q;
    pdz_d = pdz_q;
    kind_d = kind_q;
    r_d = r_q;
    q_d = q_q;
    mb_d = mb_q;
    e_d = e_q;
    cnt_d = cnt_q;
    re_d = re_q;
    dz_d = dz_q;
    nv_d = nv_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        a_d = op_a;
        b_d = op_b;
        sp_d = mode_fp;
        rm_d = round_mode;
        dz_d = 1'b0;
        nv_d = 1'b0;
        state_d = UNPACK;
      end
      UNPACK: begin
        s_d = sa ^ sb;
        kind_d = kind_u;
        pdz_d = (kind_u == K_INF) & ~ia;
        mb_d = mb;
        r_d = lt ? {1'b0, ma, 1'b0} : {2'b0, ma};
        q_d = '0;
        e_d = {2'b0, ea} - {2'b0, eb} + (sp_q ? 10'd127 : 10'd15) - {9'b0, lt};
        cnt_d = sp_q ? 5'd25 : 5'd12;
        state_d = kind_u == K_NORM ? DIVIDE : ROUND;
      end
      DIVIDE: begin
        r_d = (qbit ? diff : r_q) << 1;
        q_d = {q_q[23:0], qbit};
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd0) state_d = ROUND;
      end
      ROUND: begin
        re_d = res;
        dz_d = pdz_q;
        nv_d = kind_q == K_NAN;
        done_d = 1'b1;
        state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      sp_q <= 1'b0;
      rm_q <= 1'b0;
      s_q <= 1'b0;
      pdz_q <= 1'b0;
      kind_q <= K_NORM;
      r_q <= '0;
      q_q <= '0;
      mb_q <= '0;
      e_q <= '0;
      cnt_q <= '0;
      re_q <= '0;
      dz_q <= 1'b0;
      nv_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      sp_q <= sp_d;
      rm_q <= rm_d;
      s_q <= s_d;
      pdz_q <= pdz_d;
      kind_q <= kind_d;
      r_q <= r_d;
      q_q <= q_d;
      mb_q <= mb_d;
      e_q <= e_d;
      cnt_q <= cnt_d;
      re_q <= re_d;
      dz_q <= dz_d;
      nv_q <= nv_d;
      done_q <= done_d;
    end
  end
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign re = re_q;
  assign flag_dz = dz_q;
  assign flag_nv = nv_q;
endmodule

// File: tb/tb_fdiv_seq.sv
// tb_fdiv_seq: directed table, random ops against an integer-division model, handshake corners
module tb_fdiv_seq;
  logic clk = 1'b0;
  logic rst, start, mode_fp, round_mode, busy, done, flag_dz, flag_nv;
  logic [31:0] op_a, op_b, re;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  fdiv_seq dut (.clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
                .mode_fp(mode_fp), .round_mode(round_mode), .busy(busy), .done(done),
                .re(re), .flag_dz(flag_dz), .flag_nv(flag_nv));
  typedef struct {
    logic [31:0] a, b;
    logic sp, rm;
    logic [31:0] re;
    logic dz, nv;
    int lat;
  } vec_t;
  vec_t tv[$];
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask
  task automatic add(input logic [31:0] a, input logic [31:0] b, input logic sp, input logic rm,
                     input logic [31:0] r, input logic dz, input logic nv, input int lat);
    vec_t v;
    v.a = a; v.b = b; v.sp = sp; v.rm = rm; v.re = r; v.dz = dz; v.nv = nv; v.lat = lat;
    tv.push_back(v);
  endtask
  function automatic logic [31:0] pack(input logic sp, input logic s, input int e, input longint f);
    return sp ? {s, e[7:0], f[22:0]} : {16'h0, s, e[4:0], f[9:0]};
  endfunction
  // Value-level reference: exact integer quotient with spare bits, then IEEE rounding
  function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic sp, input logic rm, output int lat);
    int fw, emax, bias, ea, eb, e;
    longint fa, fb, ma, mb, num, q, rem, mant, mask;
    logic s, st;
    fw = sp ? 23 : 10;
    emax = sp ? 255 : 31;
    bias = sp ? 127 : 15;
    mask = (longint'(1) << fw) - 1;
    ea = int'(a >> fw) & emax;
    eb = int'(b >> fw) & emax;
    fa = longint'(a) & mask;
    fb = longint'(b) & mask;
    s = sp ? a[31] ^ b[31] : a[15] ^ b[15];
    lat = 2;
    if ((ea == emax && fa != 0) || (eb == emax && fb != 0) || (ea == 0 && eb == 0) ||
        (ea == emax && eb == emax))
      return {2'b10, sp ? 32'h7FC00000 : 32'h00007E00};
    if (ea == emax || eb == 0) return {1'b0, ea != emax, pack(sp, s, emax, 0)};
    if (ea == 0 || eb == emax) return {2'b00, pack(sp, s, 0, 0)};
    lat = sp ? 28 : 15;
    ma = fa | (longint'(1) << fw);
    mb = fb | (longint'(1) << fw);
    num = ma << (fw + 3);
    q = num / mb;
    rem = num % mb;
    e = ea - eb + bias;
    if (q >= (longint'(1) << (fw + 3))) begin
      st = q[0] || rem != 0;
      q = q >> 1;
    end else begin
      st = rem != 0;
      e = e - 1;
    end
    mant = q >> 2;
    if (!rm && q[1] && (q[0] || st || mant[0])) mant = mant + 1;
    if (mant == (longint'(1) << (fw + 1))) begin
      mant = mant >> 1;
      e = e + 1;
    end
    if (e >= emax) return {2'b00, rm ? pack(sp, s, emax - 1, mask) : pack(sp, s, emax, 0)};
    if (e <= 0) return {2'b00, pack(sp, s, 0, 0)};
    return {2'b00, pack(sp, s, e, mant & mask)};
  endfunction
  task automatic wait_done(output int lat);
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sp, input logic rm,
                        output logic [31:0] r, output logic dz, output logic nv, output int lat);
    op_a = a; op_b = b; mode_fp = sp; round_mode = rm; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    op_a = $urandom; op_b = $urandom; mode_fp = ~sp; round_mode = ~rm;
    wait_done(lat);
    r = re; dz = flag_dz; nv = flag_nv;
  endtask
  initial begin
    logic [31:0] r, a, b;
    logic dz, nv, sp, rm;
    logic [33:0] m;
    int lat, elat, cnt;
    rst = 1'b1; start = 1'b0; op_a = '0; op_b = '0; mode_fp = 1'b1; round_mode = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_re", re, 32'd0);
    chk("rst_flags", {30'd0, flag_dz, flag_nv}, 32'd0);
    rst = 1'b0;
    add(32'h40C00000, 32'h40000000, 1, 0, 32'h40400000, 0, 0, 28);
    add(32'h3F800000, 32'h40400000, 1, 0, 32'h3EAAAAAB, 0, 0, 28);
    add(32'h3F800000, 32'h40400000, 1, 1, 32'h3EAAAAAA, 0, 0, 28);
    add(32'h40400000, 32'h00000000, 1, 0, 32'h7F800000, 1, 0, 2);
    add(32'h00000000, 32'h80000000, 1, 0, 32'h7FC00000, 0, 1, 2);
    add(32'h00003C00, 32'h00004000, 0, 0, 32'h00003800, 0, 0, 15);
    add(32'hDEAD3C00, 32'hBEEF4000, 0, 0, 32'h00003800, 0, 0, 15);
    add(32'h00007BFF, 32'h00003400, 0, 1, 32'h00007BFF, 0, 0, 15);
    add(32'h00007BFF, 32'h00003400, 0, 0, 32'h00007C00, 0, 0, 15);
    add(32'h7F000000, 32'h3E800000, 1, 0, 32'h7F800000, 0, 0, 28);
    add(32'h00800000, 32'h4F000000, 1, 0, 32'h00000000, 0, 0, 28);
    add(32'h7F800000, 32'hFF800000, 1, 0, 32'h7FC00000, 0, 1, 2);
    add(32'h00007E01, 32'h00003C00, 0, 0, 32'h00007E00, 0, 1, 2);
    add(32'h80000000, 32'h3F800000, 1, 0, 32'h80000000, 0, 0, 2);
    add(32'h3F800000, 32'hFF800000, 1, 0, 32'h80000000, 0, 0, 2);
    add(32'h00003C00, 32'h00008000, 0, 0, 32'h0000FC00, 1, 0, 2);
    add(32'h7F800000, 32'h00000000, 1, 0, 32'h7F800000, 0, 0, 2);
    add(32'h00000001, 32'h3F800000, 1, 0, 32'h00000000, 0, 0, 2);
    foreach (tv[i]) begin
      run_op(tv[i].a, tv[i].b, tv[i].sp, tv[i].rm, r, dz, nv, lat);
      chk($sformatf("vec%0d_re", i), r, tv[i].re);
      chk($sformatf("vec%0d_dz", i), 32'(dz), 32'(tv[i].dz));
      chk($sformatf("vec%0d_nv", i), 32'(nv), 32'(tv[i].nv));
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(tv[i].lat));
    end
    @(posedge clk);
    #1;
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("idle_after_done", 32'(busy), 32'd0);
    for (int n = 0; n < 250; n++) begin
      sp = 1'($urandom_range(0, 1));
      rm = 1'($urandom_range(0, 1));
      a = $urandom;
      b = $urandom;
      if (sp && $urandom_range(0, 3) != 0) begin
        a[30:23] = 8'($urandom_range(100, 154));
        b[30:23] = 8'($urandom_range(100, 154));
      end
      m = model(a, b, sp, rm, elat);
      run_op(a, b, sp, rm, r, dz, nv, lat);
      chk($sformatf("rnd%0d_re a=%h b=%h sp=%0d rm=%0d", n, a, b, sp, rm), r, m[31:0]);
      chk($sformatf("rnd%0d_dz", n), 32'(dz), 32'(m[32]));
      chk($sformatf("rnd%0d_nv", n), 32'(nv), 32'(m[33]));
      chk($sformatf("rnd%0d_lat", n), 32'(lat), 32'(elat));
    end
    run_op(32'h40400000, 32'h0, 1, 0, r, dz, nv, lat);
    chk("dz_set", 32'(dz), 32'd1);
    op_a = 32'h40C00000; op_b = 32'h40000000; mode_fp = 1'b1; round_mode = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("dz_clear_at_accept", 32'(flag_dz), 32'd0);
    chk("re_hold_while_busy", re, 32'h7F800000);
    wait_done(lat);
    chk("after_clear_re", re, 32'h40400000);
    chk("after_clear_lat", 32'(lat), 32'd28);
    @(posedge clk);
    #1;
    op_a = 32'h40C00000; op_b = 32'h40000000; mode_fp = 1'b1; round_mode = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    op_a = 32'h3F800000; op_b = 32'h40400000;
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      start = (k == 5);
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        break;
      end
    end
    start = 1'b0;
    chk("ignore_lat", 32'(lat), 32'd28);
    chk("ignore_re", re, 32'h40400000);
    cnt = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done || busy) cnt++;
    end
    chk("ignore_no_second_op", 32'(cnt), 32'd0);
    op_a = 32'h3F800000; op_b = 32'h40400000; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_re", re, 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    rst = 1'b0;
    cnt = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) cnt++;
    end
    chk("abort_no_done", 32'(cnt), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
